// File: rtl/axis_downsize_arbiter.sv
// Round-robin packet arbiter sharing one 2W-to-W downsizer; grant is held from first beat through tlast.
// Two cycles from an idle request to out_tvalid; inputs stall while the output register is full and undrained.
module axis_downsize_arbiter #(
  parameter int N  = 4,
  parameter int W  = 32,
  parameter int IW = $clog2(N)
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic [N*2*W-1:0]  in_tdata,
  input  logic [N-1:0]      in_tvalid,
  input  logic [N-1:0]      in_tlast,
  output logic [N-1:0]      in_tready,
  output logic [2*W-1:0]    out_tdata,
  output logic              out_tlast,
  output logic [IW-1:0]     out_tid,
  output logic              out_tvalid,
  input  logic              out_tready
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               state, state_nxt;
  logic [IW-1:0]        gnt, gnt_nxt;
  logic [IW-1:0]        ptr, ptr_nxt;
  logic [IW-1:0]        winner, cand;
  logic                 found;
  logic                 accept;
  logic                 out_free;
  logic [N-1:0][2*W-1:0] in_dat;
  logic [2*W-1:0]       sel_tdata;

  assign in_dat    = in_tdata;
  assign sel_tdata = in_dat[gnt];
  assign out_free  = ~out_tvalid | out_tready;

  // Search ptr+1, ptr+2, ... with wrap; the last-served requester ranks lowest.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(ptr) + k) % N);
      if (!found && in_tvalid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    ptr_nxt   = ptr;
    in_tready = '0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          gnt_nxt   = winner;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        in_tready[gnt] = out_free;
        accept         = in_tvalid[gnt] & out_free;
        if (accept && in_tlast[gnt]) begin
          ptr_nxt   = gnt;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state      <= IDLE;
      gnt        <= '0;
      ptr        <= IW'(N - 1);
      out_tdata  <= '0;
      out_tlast  <= 1'b0;
      out_tid    <= '0;
      out_tvalid <= 1'b0;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      ptr   <= ptr_nxt;
      if (accept) begin
        out_tdata  <= sel_tdata;
        out_tlast  <= in_tlast[gnt];
        out_tid    <= gnt;
        out_tvalid <= 1'b1;
      end else if (out_tready) begin
        out_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axis_downsize_arbiter.sv
// Bench for axis_downsize_arbiter: per-requester beat queues drive the inputs, expected beats go to a scoreboard.
module tb_axis_downsize_arbiter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int IW = 2;
  localparam int DW = 2 * W;

  logic              aclk = 1'b0;
  logic              areset = 1'b1;
  logic [N*DW-1:0]   in_tdata;
  logic [N-1:0]      in_tvalid;
  logic [N-1:0]      in_tlast;
  logic [N-1:0]      in_tready;
  logic [DW-1:0]     out_tdata;
  logic              out_tlast;
  logic [IW-1:0]     out_tid;
  logic              out_tvalid;
  logic              out_tready;

  axis_downsize_arbiter #(.N(N), .W(W), .IW(IW)) dut (
    .aclk      (aclk),
    .areset    (areset),
    .in_tdata  (in_tdata),
    .in_tvalid (in_tvalid),
    .in_tlast  (in_tlast),
    .in_tready (in_tready),
    .out_tdata (out_tdata),
    .out_tlast (out_tlast),
    .out_tid   (out_tid),
    .out_tvalid(out_tvalid),
    .out_tready(out_tready)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {logic [DW-1:0] data; logic last;} beat_t;
  typedef struct packed {logic [DW-1:0] data; logic last; logic [IW-1:0] id;} exp_t;
  typedef struct {int src; int nbeats; int exp_lat;} vec_t;

  beat_t             rq [N][$];
  exp_t              exp_q[$];
  logic              rdy_pat[$];
  int                hs_q[$];
  logic [N-1:0]      hold = '0;
  int                nacc[N];
  int                cyc = 0;
  int                n_hs = 0;
  int                n_stall = 0;
  int                n_checks = 0;
  int                n_pass = 0;
  logic [N-1:0][DW-1:0] drv_dat;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual %h required %h", name, act, req);
  endtask

  function automatic logic [DW-1:0] mk(input int src, input int pkt, input int b);
    return {8'(src), 8'(pkt), 40'h0, 8'(8'hA1 + b)};
  endfunction

  task automatic load_pkt(input int src, input int pkt, input int nb);
    for (int b = 0; b < nb; b++) begin
      beat_t bt;
      exp_t  e;
      bt.data = mk(src, pkt, b);
      bt.last = (b == nb - 1);
      rq[src].push_back(bt);
      e.data = bt.data;
      e.last = bt.last;
      e.id   = IW'(src);
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_drain(input string name);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge aclk);
      done = (exp_q.size() == 0) && !out_tvalid &&
             (rq[0].size() + rq[1].size() + rq[2].size() + rq[3].size() == 0);
    end
    chk(name, done, 1);
    repeat (2) @(negedge aclk);
  endtask

  task automatic wait_nacc(input int src, input int n, input string name);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge aclk);
      seen = (nacc[src] >= n);
    end
    chk(name, seen, 1);
  endtask

  task automatic do_reset();
    areset = 1'b1;
    repeat (2) @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);
  endtask

  // Driver: retire accepted beats after each edge, then present each queue's head.
  initial begin
    logic [N-1:0] acc;
    in_tvalid  = '0;
    in_tlast   = '0;
    in_tdata   = '0;
    drv_dat    = '0;
    out_tready = 1'b1;
    for (int i = 0; i < N; i++) nacc[i] = 0;
    forever begin
      @(negedge aclk);
      acc = in_tvalid & in_tready & {N{~areset}};
      @(posedge aclk);
      cyc++;
      #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i] && rq[i].size() > 0) begin
          void'(rq[i].pop_front());
          nacc[i]++;
        end
      end
      out_tready = (rdy_pat.size() > 0) ? rdy_pat.pop_front() : 1'b1;
      for (int i = 0; i < N; i++) begin
        if (rq[i].size() > 0 && !hold[i]) begin
          in_tvalid[IW'(i)] = 1'b1;
          in_tlast[IW'(i)]  = rq[i][0].last;
          drv_dat[IW'(i)]   = rq[i][0].data;
        end else begin
          in_tvalid[IW'(i)] = 1'b0;
          in_tlast[IW'(i)]  = 1'($urandom_range(0, 1));
          drv_dat[IW'(i)]   = {$urandom, $urandom};
        end
      end
      in_tdata = drv_dat;
    end
  end

  // Monitor: ready one-hot, output stability under stall, scoreboard compare on handshake.
  initial begin
    logic prev_stall;
    exp_t held;
    exp_t e;
    prev_stall = 1'b0;
    forever begin
      @(negedge aclk);
      if (areset) begin
        prev_stall = 1'b0;
        continue;
      end
      chk("tready_onehot", $countones(in_tready) <= 1, 1);
      if (prev_stall) begin
        chk("stall_valid", out_tvalid, 1);
        chk("stall_data", out_tdata, held.data);
        chk("stall_last", out_tlast, held.last);
        chk("stall_tid", out_tid, held.id);
      end
      prev_stall = out_tvalid && !out_tready;
      if (prev_stall) begin
        held = {out_tdata, out_tlast, out_tid};
        n_stall++;
        chk("stall_no_ready", in_tready, 0);
      end
      if (out_tvalid && out_tready) begin
        n_hs++;
        hs_q.push_back(cyc);
        chk("sb_expected_beat", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("out_tdata", out_tdata, e.data);
          chk("out_tlast", out_tlast, e.last);
          chk("out_tid", out_tid, e.id);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vt[4];
    int   t0, lat, hs0, s0;
    vt[0] = '{2, 3, 2};
    vt[1] = '{0, 1, 2};
    vt[2] = '{3, 2, 2};
    vt[3] = '{1, 4, 2};

    repeat (3) @(negedge aclk);
    chk("rst_out_tvalid", out_tvalid, 0);
    chk("rst_out_tdata", out_tdata, 0);
    chk("rst_out_tlast", out_tlast, 0);
    chk("rst_out_tid", out_tid, 0);
    chk("rst_in_tready", in_tready, 0);
    areset = 1'b0;
    repeat (2) @(negedge aclk);

    // Single-packet vectors: latency, beat count and contents.
    for (int v = 0; v < 4; v++) begin
      hs0 = n_hs;
      load_pkt(vt[v].src, v, vt[v].nbeats);
      @(posedge aclk);
      #2;
      t0  = cyc;
      lat = -1;
      for (int k = 0; k < 20 && lat < 0; k++) begin
        @(negedge aclk);
        if (out_tvalid) lat = cyc - t0;
      end
      chk("first_latency", lat, vt[v].exp_lat);
      wait_drain("pkt_drain");
      chk("pkt_beats", n_hs - hs0, vt[v].nbeats);
    end

    // Reset in the middle of a packet; pointer must return to N-1 so requester 0 beats 3.
    for (int i = 0; i < N; i++) nacc[i] = 0;
    load_pkt(1, 10, 3);
    wait_nacc(1, 1, "rst_wait_beat");
    @(posedge aclk);
    #3;
    chk("pre_reset_valid", out_tvalid, 1);
    areset = 1'b1;
    #1;
    chk("async_reset_valid", out_tvalid, 0);
    chk("async_reset_ready", in_tready, 0);
    rq[1].delete();
    exp_q.delete();
    repeat (2) @(negedge aclk);
    areset = 1'b0;
    load_pkt(0, 11, 2);
    load_pkt(3, 11, 2);
    wait_drain("rst_drain");

    // All requesters valid: expect 0,0,1,1,2,2,3,3,0,0.
    do_reset();
    load_pkt(0, 20, 2);
    load_pkt(1, 20, 2);
    load_pkt(2, 20, 2);
    load_pkt(3, 20, 2);
    load_pkt(0, 21, 2);
    wait_drain("rr_drain");

    // Backpressure, including a stalled tlast while the next requester is waiting.
    s0 = n_stall;
    rdy_pat = '{1, 1, 1, 0, 0, 1, 0, 0, 1, 1, 1, 0, 0, 0, 1, 1};
    load_pkt(2, 30, 4);
    load_pkt(3, 30, 2);
    wait_drain("bp_drain");
    chk("bp_stalls_seen", n_stall > s0, 1);

    // Atomicity: requester 1 pauses mid-packet, requester 0 must keep waiting.
    for (int i = 0; i < N; i++) nacc[i] = 0;
    load_pkt(1, 40, 4);
    wait_nacc(1, 2, "atom_wait_beat");
    hold[1] = 1'b1;
    load_pkt(0, 40, 2);
    repeat (4) begin
      @(negedge aclk);
      chk("hold_grant", in_tready[0], 0);
    end
    hold[1] = 1'b0;
    wait_drain("atom_drain");

    // Back-to-back single-beat packets from requester 3: one beat every 2 cycles.
    hs_q.delete();
    for (int p = 0; p < 4; p++) load_pkt(3, 50 + p, 1);
    wait_drain("sb_drain");
    chk("sb_count", hs_q.size(), 4);
    for (int j = 1; j < hs_q.size(); j++) chk("sb_gap", hs_q[j] - hs_q[j-1], 2);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axis_downsize_arbiter.md
Name: axis_downsize_arbiter

Overview:
- Round-robin packet arbiter that shares one 2W-to-W AXI-Stream downsizer among N requesters.
- Merges N input streams, each 2*W bits wide, into one registered output stream that feeds the downsizer input.
- Holds the grant for a whole packet, up to and including the tlast beat, so a packet's halves are never interleaved with another requester's.
- Emits the source index alongside each beat for downstream demux and debug.

Parameters:
- N, 4, number of requesters (2..16).
- W, 32, downsizer output width; every input and output beat here is 2*W bits.
- IW, $clog2(N), width of the source index.

Ports:
- aclk  in  1  clock; all logic rising-edge.
- areset  in  1  reset, asynchronous, active-high.
- in_tdata  in  N*2*W  requester i occupies bits [i*2W +: 2W].
- in_tvalid  in  N  per-requester valid.
- in_tlast  in  N  per-requester end of packet.
- in_tready  out  N  per-requester ready; at most one bit set per cycle.
- out_tdata  out  2*W  registered beat toward the downsizer.
- out_tlast  out  1  registered end of packet.
- out_tid  out  IW  index of the requester that produced the beat.
- out_tvalid  out  1  registered valid.
- out_tready  in  1  downsizer ready.

Behaviour:
- Reset (async assert, released synchronously to aclk):
  - out_tvalid=0; out_tdata, out_tlast, out_tid = 0.
  - state=IDLE, gnt=0, ptr=N-1, so requester 0 has top priority after reset.
  - Reset mid-packet discards the partial packet; no beat is replayed.
- State machine with two states, IDLE and BUSY:
  - IDLE: all in_tready=0. If any in_tvalid is set, the winner is the first set bit searching ptr+1, ptr+2, … with wrap modulo N. Register gnt=winner; next state BUSY. With no valid, stay IDLE.
  - BUSY: in_tready[gnt] = ~out_tvalid | out_tready; all other ready bits are 0.
  - BUSY, accepted beat (in_tvalid[gnt] & in_tready[gnt]): load out_tdata, out_tlast, out_tid=gnt; set out_tvalid=1.
  - BUSY, accepted beat with in_tlast[gnt]=1: ptr=gnt; next state IDLE.
- Output register:
  - If out_tvalid & out_tready and no new beat is accepted, out_tvalid goes to 0.
  - While out_tvalid & ~out_tready, out_tdata, out_tlast and out_tid hold stable.
- Latency and throughput:
  - From in_tvalid rising in IDLE to out_tvalid: 2 cycles (grant cycle, then register cycle).
  - Within a packet: 1 beat per cycle when out_tready=1.
  - Exactly 1 arbitration bubble per packet on the input side.
- Fairness: with all N requesters continuously valid, packets are served in order 0,1,…,N-1,0,…. No requester waits more than N-1 packets.
- Boundary conditions:
  - Granted requester drops tvalid mid-packet: grant is held indefinitely, with no timeout.
  - Single-beat packet (tlast on the first beat): back to IDLE after that beat.
  - A non-granted requester's inputs never affect outputs.
  - Downsizer stalled while the tlast beat sits in the output register: the arbiter may enter IDLE and re-grant. The next beat is accepted only after the register drains.
  - ptr updates only on a tlast acceptance.

Test Plan:
- Reset then single requester: requester 2 sends a 3-beat packet 0x…A1, A2, A3 (tlast on A3) with out_tready=1. Required: out_tvalid first rises 2 cycles after in_tvalid; beats appear in order with out_tid=2; out_tlast only on A3.
- All 4 requesters valid, 2-beat packets each, out_tready=1. Required: out_tid sequence 0,0,1,1,2,2,3,3,0,0; in_tready is one-hot or zero every cycle.
- Backpressure: out_tready toggles 1,0,0,1 during a 4-beat packet. Required: out_tdata, out_tlast and out_tid stable while stalled; no beat lost or duplicated; in_tready[gnt]=0 while out_tvalid & ~out_tready.
- Packet atomicity: requester 1 mid-packet (beat 2 of 4) while requester 0 raises valid. Required: requester 0's beats appear only after requester 1's tlast beat has been output.
- Reset mid-packet: areset asserted during beat 2 of 3. Required: out_tvalid=0 immediately (asynchronously); after release, requester 0 wins when requesters 0 and 3 are both valid.
- Single-beat packets back-to-back from requester 3 alone: one out beat every 2 cycles, each with out_tlast=1 and out_tid=3.
